// File: rtl/hpdcache_cmo_range.sv
// Cache-management-operation handler for HPDcache: fence, invalidate by
// line / set / all and multi-line invalidate by range, with directory port
// arbitration and a registered completion pulse.
module hpdcache_cmo_range #(
   parameter int ADDR_WIDTH   = 49,
   parameter int OFFSET_WIDTH = 6,
   parameter int SETS         = 64,
   parameter int WAYS         = 8,
   parameter int CNT_WIDTH    = 16,
   localparam int SET_W       = $clog2(SETS),
   localparam int NLINE_W     = ADDR_WIDTH - OFFSET_WIDTH,
   localparam int TAG_W       = NLINE_W - SET_W,
   localparam int WDATA_W     = (WAYS > CNT_WIDTH) ? WAYS : CNT_WIDTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  wbuf_empty_i,
   input  logic                  mshr_empty_i,
   input  logic                  rtab_empty_i,
   input  logic                  ctrl_empty_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic [4:0]            req_op_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [WDATA_W-1:0]    req_wdata_i,
   output logic                  req_wait_o,
   output logic                  done_o,
   output logic                  wbuf_flush_all_o,
   input  logic                  dir_gnt_i,
   output logic                  dir_check_o,
   output logic [SET_W-1:0]      dir_check_set_o,
   output logic [TAG_W-1:0]      dir_check_tag_o,
   input  logic [WAYS-1:0]       dir_check_hit_way_i,
   output logic                  dir_inval_o,
   output logic [SET_W-1:0]      dir_inval_set_o,
   output logic [WAYS-1:0]       dir_inval_way_o
);

   typedef enum logic [2:0] {
      IDLE, FENCE_WAIT, INVAL_WAIT, CHECK, CHECK_RSP, INVAL
   } state_t;

   state_t               state_q, state_d;
   logic [4:0]           op_q;
   logic [NLINE_W-1:0]   line_q;
   logic [WAYS-1:0]      mask_q;
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [SET_W-1:0]     set_cnt_q;
   logic [WAYS-1:0]      hit_q;
   logic                 done_q;
   logic                 complete;
   logic                 accept;
   logic                 drained;
   logic                 req_is_check;
   logic                 op_is_check;
   logic                 unused_offset;

   assign unused_offset = ^req_addr_i[OFFSET_WIDTH-1:0];
   assign accept        = req_valid_i && (state_q == IDLE) && $onehot(req_op_i);
   assign drained       = mshr_empty_i && rtab_empty_i && ctrl_empty_i;
   assign req_is_check  = req_op_i[1] | req_op_i[4];
   assign op_is_check   = op_q[1] | op_q[4];
   assign done_o        = done_q;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic and completion detection
   always_comb begin
      state_d  = state_q;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (req_op_i[0]) begin
                  if (wbuf_empty_i && rtab_empty_i) complete = 1'b1;
                  else                              state_d  = FENCE_WAIT;
               end else if (req_op_i[4] && (req_wdata_i[CNT_WIDTH-1:0] == '0)) begin
                  complete = 1'b1;
               end else if (drained) begin
                  state_d = req_is_check ? CHECK : INVAL;
               end else begin
                  state_d = INVAL_WAIT;
               end
            end
         end
         FENCE_WAIT: begin
            if (wbuf_empty_i && rtab_empty_i) begin
               state_d  = IDLE;
               complete = 1'b1;
            end
         end
         INVAL_WAIT: begin
            if (drained) state_d = op_is_check ? CHECK : INVAL;
         end
         CHECK: begin
            if (dir_gnt_i) state_d = CHECK_RSP;
         end
         CHECK_RSP: begin
            if (dir_check_hit_way_i != '0) begin
               state_d = INVAL;
            end else if (op_q[4] && (cnt_q != CNT_WIDTH'(1))) begin
               state_d = CHECK;
            end else begin
               state_d  = IDLE;
               complete = 1'b1;
            end
         end
         INVAL: begin
            if (dir_gnt_i) begin
               if (op_q[3] && (set_cnt_q != SET_W'(SETS-1))) begin
                  state_d = INVAL;
               end else if (op_q[4] && (cnt_q != CNT_WIDTH'(1))) begin
                  state_d = CHECK;
               end else begin
                  state_d  = IDLE;
                  complete = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request latching, hit capture and range/set-walk bookkeeping
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q      <= '0;
         line_q    <= '0;
         mask_q    <= '0;
         cnt_q     <= '0;
         set_cnt_q <= '0;
         hit_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= complete;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  op_q      <= req_op_i;
                  line_q    <= req_addr_i[ADDR_WIDTH-1:OFFSET_WIDTH];
                  mask_q    <= req_wdata_i[WAYS-1:0];
                  cnt_q     <= req_wdata_i[CNT_WIDTH-1:0];
                  set_cnt_q <= '0;
               end
            end
            CHECK_RSP: begin
               hit_q <= dir_check_hit_way_i;
               if ((dir_check_hit_way_i == '0) && op_q[4]) begin
                  cnt_q  <= cnt_q - CNT_WIDTH'(1);
                  line_q <= line_q + NLINE_W'(1);
               end
            end
            INVAL: begin
               if (dir_gnt_i) begin
                  if (op_q[3]) set_cnt_q <= set_cnt_q + SET_W'(1);
                  if (op_q[4]) begin
                     cnt_q  <= cnt_q - CNT_WIDTH'(1);
                     line_q <= line_q + NLINE_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from the current state
   always_comb begin
      req_ready_o      = (state_q == IDLE);
      req_wait_o       = (state_q == FENCE_WAIT) || (state_q == INVAL_WAIT);
      wbuf_flush_all_o = 1'b0;
      dir_check_o      = 1'b0;
      dir_check_set_o  = '0;
      dir_check_tag_o  = '0;
      dir_inval_o      = 1'b0;
      dir_inval_set_o  = '0;
      dir_inval_way_o  = '0;
      case (state_q)
         IDLE:       wbuf_flush_all_o = accept && req_op_i[0] && rtab_empty_i;
         FENCE_WAIT: wbuf_flush_all_o = rtab_empty_i;
         CHECK: begin
            dir_check_o     = 1'b1;
            dir_check_set_o = line_q[SET_W-1:0];
            dir_check_tag_o = line_q[NLINE_W-1:SET_W];
         end
         INVAL: begin
            dir_inval_o = 1'b1;
            if (op_q[3]) begin
               dir_inval_set_o = set_cnt_q;
               dir_inval_way_o = '1;
            end else if (op_q[2]) begin
               dir_inval_set_o = line_q[SET_W-1:0];
               dir_inval_way_o = mask_q;
            end else begin
               dir_inval_set_o = line_q[SET_W-1:0];
               dir_inval_way_o = hit_q;
            end
         end
         default: ;
      endcase
   end

   // Malformed requests and requests presented while busy are ignored; flag them
   a_onehot_op: assert property (@(posedge clk_i) disable iff (!rst_ni)
      req_valid_i |-> $onehot(req_op_i));
   a_valid_when_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
      req_valid_i |-> req_ready_o);

endmodule

// File: tb/tb_hpdcache_cmo_range.sv
// Directed self-checking bench for hpdcache_cmo_range.
module tb_hpdcache_cmo_range;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wbuf_empty, mshr_empty, rtab_empty, ctrl_empty;
   logic        req_valid, req_ready;
   logic [4:0]  req_op;
   logic [48:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_wait, done, wbuf_flush_all;
   logic        dir_gnt, dir_check, dir_inval;
   logic [5:0]  dir_check_set, dir_inval_set;
   logic [36:0] dir_check_tag;
   logic [7:0]  dir_hit, dir_inval_way;

   int passCount = 0;
   int totalCount = 0;

   hpdcache_cmo_range dut (
      .clk_i(clk), .rst_ni(rst_n),
      .wbuf_empty_i(wbuf_empty), .mshr_empty_i(mshr_empty),
      .rtab_empty_i(rtab_empty), .ctrl_empty_i(ctrl_empty),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_op_i(req_op), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .req_wait_o(req_wait), .done_o(done), .wbuf_flush_all_o(wbuf_flush_all),
      .dir_gnt_i(dir_gnt), .dir_check_o(dir_check),
      .dir_check_set_o(dir_check_set), .dir_check_tag_o(dir_check_tag),
      .dir_check_hit_way_i(dir_hit), .dir_inval_o(dir_inval),
      .dir_inval_set_o(dir_inval_set), .dir_inval_way_o(dir_inval_way)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      totalCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [4:0] op,
                                input logic [48:0] addr, input logic [15:0] wdata);
      req_valid = valid;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
   endtask

   function automatic logic [48:0] lineAddr(input int tag, input int set);
      logic [48:0] a;
      a = ((49'(tag) << 6) | 49'(set)) << 6;
      return a;
   endfunction

   task automatic expectDir(input string tag, input logic chk, input int cset, input int ctag,
                            input logic inv, input int iset, input int iway);
      checkOutput({tag, "_check"}, {dir_check, 6'(dir_check_set), 37'(dir_check_tag)},
                  {chk, 6'(cset), 37'(ctag)});
      checkOutput({tag, "_inval"}, {dir_inval, dir_inval_set, dir_inval_way},
                  {inv, 6'(iset), 8'(iway)});
   endtask

   initial begin
      rst_n = 1'b0;
      wbuf_empty = 1'b1; mshr_empty = 1'b1; rtab_empty = 1'b1; ctrl_empty = 1'b1;
      dir_gnt = 1'b0; dir_hit = '0;
      applyStimulus(1'b0, 5'b0, '0, '0);
      tick(); tick();
      checkOutput("rst_ready", req_ready, 1);
      checkOutput("rst_misc", {req_wait, done, wbuf_flush_all, dir_check, dir_inval}, 0);
      expectDir("rst", 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      tick();

      // Fence with a busy write buffer for five cycles
      $display("[TB] fence");
      applyStimulus(1'b1, 5'b00001, '0, '0);
      wbuf_empty = 1'b0;
      #1;
      checkOutput("fence_acc_flush", wbuf_flush_all, 1);
      checkOutput("fence_acc_wait", req_wait, 0);
      tick();
      applyStimulus(1'b0, 5'b0, '0, '0);
      for (int i = 1; i <= 5; i++) begin
         wbuf_empty = (i == 5);
         #1;
         checkOutput("fence_flush", wbuf_flush_all, 1);
         checkOutput("fence_wait", {req_wait, done, req_ready}, 3'b100);
         tick();
      end
      checkOutput("fence_done", {done, req_ready, wbuf_flush_all, req_wait}, 4'b1100);
      tick();
      checkOutput("fence_done_once", done, 0);

      // Invalidate a set with an explicit way mask and a stalled grant
      $display("[TB] inval_set");
      applyStimulus(1'b1, 5'b00100, lineAddr(5, 3), 16'h0081);
      #1;
      expectDir("set_acc", 0, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(1'b0, 5'b0, '0, '0);
      for (int i = 1; i <= 3; i++) begin
         dir_gnt = (i == 3);
         #1;
         expectDir("set_inv", 0, 0, 0, 1, 3, 8'h81);
         checkOutput("set_nodone", done, 0);
         tick();
      end
      dir_gnt = 1'b0;
      checkOutput("set_done", {done, req_ready, dir_inval}, 3'b110);
      tick();

      // Invalidate all, held off by a busy MSHR
      $display("[TB] inval_all");
      applyStimulus(1'b1, 5'b01000, '0, '0);
      mshr_empty = 1'b0;
      dir_gnt = 1'b1;
      tick();
      applyStimulus(1'b0, 5'b0, '0, '0);
      for (int i = 1; i <= 4; i++) begin
         mshr_empty = (i == 4);
         #1;
         checkOutput("all_wait", {req_wait, dir_inval}, 2'b10);
         tick();
      end
      for (int s = 0; s < 64; s++) begin
         checkOutput("all_inv", {done, dir_inval, dir_inval_set, dir_inval_way},
                     {1'b0, 1'b1, 6'(s), 8'hFF});
         tick();
      end
      checkOutput("all_done", {done, req_ready, dir_inval}, 3'b110);
      tick();
      checkOutput("all_done_once", done, 0);

      // Invalidate a single line that hits
      $display("[TB] inval_nline");
      applyStimulus(1'b1, 5'b00010, lineAddr(3, 7), '0);
      tick();
      applyStimulus(1'b0, 5'b0, '0, '0);
      expectDir("nl_c1", 1, 7, 3, 0, 0, 0);
      tick();
      dir_hit = 8'h20;
      #1;
      expectDir("nl_rsp", 0, 0, 0, 0, 0, 0);
      tick();
      dir_hit = '0;
      expectDir("nl_inv", 0, 0, 0, 1, 7, 8'h20);
      tick();
      checkOutput("nl_done", {done, req_ready}, 2'b11);
      tick();

      // Range of four lines crossing a set boundary into the next tag
      $display("[TB] inval_range");
      applyStimulus(1'b1, 5'b10000, lineAddr(9, 62), 16'd4);
      tick();
      applyStimulus(1'b0, 5'b0, '0, '0);
      expectDir("rg_c62", 1, 62, 9, 0, 0, 0);
      tick();
      dir_hit = 8'h02; #1;
      expectDir("rg_r62", 0, 0, 0, 0, 0, 0);
      tick();
      dir_hit = '0;
      expectDir("rg_i62", 0, 0, 0, 1, 62, 8'h02);
      tick();
      expectDir("rg_c63", 1, 63, 9, 0, 0, 0);
      tick();
      expectDir("rg_r63", 0, 0, 0, 0, 0, 0);
      tick();
      expectDir("rg_c0", 1, 0, 10, 0, 0, 0);
      tick();
      dir_hit = 8'h10; #1;
      expectDir("rg_r0", 0, 0, 0, 0, 0, 0);
      tick();
      dir_hit = '0;
      expectDir("rg_i0", 0, 0, 0, 1, 0, 8'h10);
      checkOutput("rg_nodone", done, 0);
      tick();
      expectDir("rg_c1", 1, 1, 10, 0, 0, 0);
      tick();
      dir_hit = 8'h01; #1;
      tick();
      dir_hit = '0;
      expectDir("rg_i1", 0, 0, 0, 1, 1, 8'h01);
      checkOutput("rg_nodone2", done, 0);
      tick();
      checkOutput("rg_done", {done, req_ready, dir_check, dir_inval}, 4'b1100);
      tick();
      checkOutput("rg_done_once", done, 0);

      // Zero-length range, with a second one accepted in the completion cycle
      $display("[TB] range count 0");
      applyStimulus(1'b1, 5'b10000, lineAddr(1, 1), 16'd0);
      #1;
      expectDir("z_acc", 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("z_done", {done, req_ready}, 2'b11);
      expectDir("z_nodir", 0, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(1'b0, 5'b0, '0, '0);
      checkOutput("z_done_b2b", {done, req_ready}, 2'b11);
      tick();
      checkOutput("z_done_end", done, 0);

      // Reset while a range op is checking the directory
      $display("[TB] reset mid-op");
      dir_gnt = 1'b0;
      applyStimulus(1'b1, 5'b10000, lineAddr(2, 4), 16'd2);
      tick();
      applyStimulus(1'b0, 5'b0, '0, '0);
      checkOutput("rs_check", dir_check, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rs_abort", {req_ready, req_wait, done, dir_check, dir_inval}, 5'b10000);
      tick(); tick();
      rst_n = 1'b1;
      dir_gnt = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("rs_idle", {req_ready, done, dir_check, dir_inval}, 4'b1000);
      end

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

   // Watchdog so the bench always terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/hpdcache_cmo_range.md
Name: hpdcache_cmo_range

Overview:
- Parametrised next-generation cache-management-operation (CMO) handler for HPDcache.
- Sits between the core-side CMO request port and the cache directory, write buffer, MSHR and replay table.
- Supports fence, invalidate-by-line, invalidate-by-set and invalidate-all, plus a new multi-line invalidate-by-range.
- Adds directory-port arbitration (grant handshake) and a registered completion pulse.

Parameters:
- ADDR_WIDTH, 49: request byte-address width.
- OFFSET_WIDTH, 6: cache-line offset bits.
- SETS, 64: directory sets (power of 2, ≥2); SET_W = log2(SETS).
- WAYS, 8: directory ways.
- CNT_WIDTH, 16: width of the range line count.
- Derived: NLINE_W = ADDR_WIDTH-OFFSET_WIDTH; TAG_W = NLINE_W-SET_W.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- wbuf_empty_i  in  1  write buffer empty
- mshr_empty_i  in  1  MSHR empty
- rtab_empty_i  in  1  replay table empty
- ctrl_empty_i  in  1  controller pipeline empty
- req_valid_i  in  1  CMO request valid
- req_ready_o  out  1  handler idle, accepts request
- req_op_i  in  5  one-hot op: [0] fence, [1] inval_nline, [2] inval_set, [3] inval_all, [4] inval_range
- req_addr_i  in  ADDR_WIDTH  target address
- req_wdata_i  in  max(WAYS,CNT_WIDTH)  way mask in [WAYS-1:0] (inval_set); line count in [CNT_WIDTH-1:0] (inval_range)
- req_wait_o  out  1  handler blocking on drain conditions
- done_o  out  1  one-cycle completion pulse
- wbuf_flush_all_o  out  1  write-buffer flush request
- dir_gnt_i  in  1  directory port granted this cycle
- dir_check_o  out  1  tag check request
- dir_check_set_o  out  SET_W  check set
- dir_check_tag_o  out  TAG_W  check tag
- dir_check_hit_way_i  in  WAYS  hit vector, valid one cycle after a granted check
- dir_inval_o  out  1  invalidate request
- dir_inval_set_o  out  SET_W  invalidate set
- dir_inval_way_o  out  WAYS  invalidate way mask

Behaviour:
- Reset: FSM to IDLE. All internal registers cleared. Outputs after reset: req_ready_o=1; all others 0, including done_o.
- Handshake: request accepted when req_valid_i && req_ready_o. req_ready_o is 1 only in IDLE. On acceptance, op, address, way mask and count are latched.
- States: IDLE, FENCE_WAIT, INVAL_WAIT, CHECK, CHECK_RSP, INVAL.
- req_wait_o = (state==FENCE_WAIT)|(state==INVAL_WAIT).
- Fence in IDLE:
  - wbuf_flush_all_o = rtab_empty_i, combinationally.
  - If wbuf_empty_i && rtab_empty_i, the op completes. Otherwise go to FENCE_WAIT.
- FENCE_WAIT: wbuf_flush_all_o = rtab_empty_i. Exit to IDLE (complete) when both are empty.
- Invalidate ops:
  - If mshr, rtab and ctrl are all empty at acceptance, go directly to the work state. Otherwise go to INVAL_WAIT and re-test each cycle.
  - Work state is CHECK for nline/range, INVAL for set/all.
- CHECK:
  - dir_check_o=1, set/tag taken from the current line register.
  - Advance to CHECK_RSP only on dir_gnt_i; otherwise hold with the request asserted.
- CHECK_RSP:
  - Capture dir_check_hit_way_i into a register and go to INVAL.
  - If the hit vector is zero, skip INVAL: advance the line (range) or complete (nline).
- INVAL:
  - dir_inval_o=1 and hold until dir_gnt_i.
  - On grant:
    - nline: way mask = captured hit; complete.
    - set: way = latched mask, set = address set; complete.
    - all: way = all ones, set = set counter; counter+1; complete after the grant with counter == SETS-1.
    - range: way = captured hit; remaining count decrements; line register +1 (carry from set into tag, so it crosses set boundaries); if remaining becomes 0 complete, else back to CHECK.
- Range arithmetic:
  - Count is an unsigned line count; count 0 completes immediately without touching the directory.
  - Line increment wraps modulo 2^NLINE_W.
  - Each line costs ≥3 cycles (CHECK, CHECK_RSP, INVAL) with zero-latency grants; a miss costs 2.
- Completion: done_o is registered and pulses 1 the cycle after the completing cycle, concurrent with req_ready_o returning to 1. A new request may be accepted in that same cycle.
- A request with non-one-hot req_op_i, or arriving while not ready, is ignored. Simulation assertions flag both.
- Asynchronous reset mid-operation aborts immediately: no done_o, no further directory requests.

Test Plan:
- Fence with wbuf_empty_i=0 for 5 cycles, rtab empty → wbuf_flush_all_o=1 from acceptance for 6 cycles; req_wait_o=1 for 5; done_o pulses once, one cycle after wbuf_empty_i rises.
- inval_set at set 3, mask 8'h81, all queues empty, dir_gnt_i held 0 for 2 cycles → dir_inval_o stays high 3 cycles with set=3, way=8'h81; done_o follows.
- inval_all with SETS=64, mshr busy 4 cycles → req_wait_o for 4 cycles, then 64 consecutive invals with set 0..63 and way 8'hFF; done_o exactly once.
- inval_range from the address whose line is at set 62, count 4, hit vectors 8'h02/0/8'h10/8'h01 → inval at set 62 way 02, none at 63, set 0 with tag+1 way 10, set 1 way 01; done_o once.
- inval_range with count 0 → no check or inval issued; done_o one cycle after acceptance.
- Reset asserted during the CHECK of a range op → all outputs drop to reset values immediately; req_ready_o=1 after release; done_o never pulses.
